// File: rtl/sonar_scan_multi.sv
// Round-robin multi-channel HC-SR04 ranger: triggers one channel at a time, times its echo in us.
// Build option SONAR_ECHO_SYNC_EN adds a 2-flop echo synchroniser ahead of the edge detector.
module sonar_scan_multi #(
    parameter int unsigned NCH        = 6,
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned GAP_US     = 2000,
    parameter int unsigned W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NCH-1:0]   ch_mask,
    output logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   echo,
    output logic             upd,
    output logic [3:0]       upd_ch,
    output logic [W-1:0]     upd_val,
    output logic             upd_to,
    output logic [NCH*W-1:0] dist_flat,
    output logic             busy
);

    localparam int unsigned PreW   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned MaxUs0 = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
    localparam int unsigned MaxUs  = (MaxUs0 > TRIG_US) ? MaxUs0 : TRIG_US;
    localparam int unsigned UsW    = $clog2(MaxUs + 1);
    // All-ones is reserved for timeout, so a valid width saturates one below it.
    localparam logic [W-1:0] WidMax = {{(W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StReport,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [UsW-1:0]   us_q, us_d;
    logic [W-1:0]     wid_q, wid_d;
    logic [3:0]       ch_q, ch_d;
    logic [3:0]       upd_ch_q, upd_ch_d;
    logic [W-1:0]     upd_val_q, upd_val_d;
    logic             upd_to_q, upd_to_d;
    logic [NCH*W-1:0] dist_q, dist_d;

    logic [NCH-1:0]   echo_s_q, echo_prev_q;
    logic [NCH-1:0]   ch_oh;
    logic             tick, rise, fall;
    logic [3:0]       nxt_ch;
    logic             rep, rep_to;
    logic [W-1:0]     rep_val;

    // ---------------------------------------------------------------- echo capture
`ifdef SONAR_ECHO_SYNC_EN
    logic [NCH-1:0] echo_meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_meta_q <= '0;
            echo_s_q    <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s_q <= '0;
        end else begin
            echo_s_q <= echo;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_prev_q <= '0;
        end else begin
            echo_prev_q <= echo_s_q;
        end
    end

    // ---------------------------------------------------------------- channel decode
    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_oh[i] = (ch_q == 4'(i));
        end
    end

    // An echo that is already high on entry never produces a rise: a real edge is required.
    assign rise = |(echo_s_q & ~echo_prev_q & ch_oh);
    assign fall = |(~echo_s_q & echo_prev_q & ch_oh);
    assign tick = (pre_q == PreW'(CLK_MHZ - 1));

    // First set mask bit strictly after the current channel, wrapping modulo NCH.
    always_comb begin
        logic [4:0] idx;
        logic       found;
        logic       hit;
        nxt_ch = ch_q;
        idx    = '0;
        found  = 1'b0;
        hit    = 1'b0;
        for (int off = 1; off <= NCH; off++) begin
            idx = 5'(ch_q) + 5'(off);
            if (idx >= 5'(NCH)) begin
                idx = idx - 5'(NCH);
            end
            hit = |(ch_mask & (NCH'(1) << idx));
            if (!found && hit) begin
                nxt_ch = idx[3:0];
                found  = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + PreW'(1);
        us_d      = tick ? us_q + UsW'(1) : us_q;
        wid_d     = wid_q;
        ch_d      = ch_q;
        upd_ch_d  = upd_ch_q;
        upd_val_d = upd_val_q;
        upd_to_d  = upd_to_q;
        dist_d    = dist_q;
        rep       = 1'b0;
        rep_to    = 1'b0;
        rep_val   = '0;

        unique case (state_q)
            StIdle: begin
                if (enable && (|ch_mask)) begin
                    ch_d    = nxt_ch;
                    state_d = StTrig;
                end
            end
            StTrig: begin
                if (tick && (us_q == UsW'(TRIG_US - 1))) begin
                    state_d = StWaitRise;
                end
            end
            StWaitRise: begin
                if (rise) begin
                    wid_d   = '0;
                    state_d = StMeasure;
                end else if (tick && (us_q == UsW'(TIMEOUT_US - 1))) begin
                    rep     = 1'b1;
                    rep_to  = 1'b1;
                    rep_val = '1;
                end
            end
            StMeasure: begin
                if (tick && (wid_q != WidMax)) begin
                    wid_d = wid_q + W'(1);
                end
                if (fall) begin
                    rep     = 1'b1;
                    rep_val = wid_d;
                end else if (tick && (us_q == UsW'(TIMEOUT_US - 1))) begin
                    rep     = 1'b1;
                    rep_to  = 1'b1;
                    rep_val = '1;
                end
            end
            StReport: begin
                state_d = StGap;
            end
            StGap: begin
                if (tick && (us_q == UsW'(GAP_US - 1))) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Result registers and dist_flat load together so they are visible alongside upd.
        if (rep) begin
            state_d   = StReport;
            upd_ch_d  = ch_q;
            upd_val_d = rep_val;
            upd_to_d  = rep_to;
            for (int i = 0; i < NCH; i++) begin
                if (ch_oh[i]) begin
                    dist_d[i*W +: W] = rep_val;
                end
            end
        end

        // The us counter keeps running into MEASURE so the timeout spans rise wait plus width.
        if (state_d != state_q) begin
            pre_d = '0;
            if (state_d != StMeasure) begin
                us_d = '0;
            end
        end
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            us_q      <= '0;
            wid_q     <= '0;
            ch_q      <= 4'(NCH - 1);
            upd_ch_q  <= '0;
            upd_val_q <= '0;
            upd_to_q  <= 1'b0;
            dist_q    <= '1;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            us_q      <= us_d;
            wid_q     <= wid_d;
            ch_q      <= ch_d;
            upd_ch_q  <= upd_ch_d;
            upd_val_q <= upd_val_d;
            upd_to_q  <= upd_to_d;
            dist_q    <= dist_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        trig = '0;
        if (state_q == StTrig) begin
            trig = ch_oh;
        end
        upd  = (state_q == StReport);
        busy = (state_q != StIdle);
    end

    assign upd_ch    = upd_ch_q;
    assign upd_val   = upd_val_q;
    assign upd_to    = upd_to_q;
    assign dist_flat = dist_q;

endmodule

// File: tb/tb_sonar_scan_multi.sv
// Directed bench for sonar_scan_multi; timing parameters are scaled down to keep the run short.
module tb_sonar_scan_multi;

    localparam int unsigned NCH        = 6;
    localparam int unsigned CLK_MHZ    = 10;
    localparam int unsigned TRIG_US    = 10;
    localparam int unsigned TIMEOUT_US = 800;
    localparam int unsigned GAP_US     = 200;
    localparam int unsigned W          = 16;
    localparam int unsigned WS         = 8;
    localparam int TRIG_CYC = TRIG_US * CLK_MHZ;
    localparam int TO_CYC   = TIMEOUT_US * CLK_MHZ;
    localparam int GAP_CYC  = GAP_US * CLK_MHZ;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable, enable_s;
    logic [NCH-1:0]    ch_mask, ch_mask_s, echo, echo_s;
    logic [NCH-1:0]    trig, trig_s;
    logic              upd, upd_s, upd_to, upd_to_s, busy, busy_s;
    logic [3:0]        upd_ch, upd_ch_s;
    logic [W-1:0]      upd_val;
    logic [WS-1:0]     upd_val_s;
    logic [NCH*W-1:0]  dist_flat;
    logic [NCH*WS-1:0] dist_flat_s;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int overlap_err = 0;
    int upd_cnt     = 0;

    sonar_scan_multi #(
        .NCH(NCH), .CLK_MHZ(CLK_MHZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
        .GAP_US(GAP_US), .W(W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .trig(trig), .echo(echo),
        .upd(upd), .upd_ch(upd_ch), .upd_val(upd_val), .upd_to(upd_to),
        .dist_flat(dist_flat), .busy(busy)
    );

    sonar_scan_multi #(
        .NCH(NCH), .CLK_MHZ(CLK_MHZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
        .GAP_US(GAP_US), .W(WS)
    ) dut_s (
        .clk(clk), .rst(rst), .enable(enable_s), .ch_mask(ch_mask_s), .trig(trig_s),
        .echo(echo_s), .upd(upd_s), .upd_ch(upd_ch_s), .upd_val(upd_val_s),
        .upd_to(upd_to_s), .dist_flat(dist_flat_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!$onehot0(trig)) overlap_err <= overlap_err + 1;
        if (upd) upd_cnt <= upd_cnt + 1;
    end

    task automatic wait_trig(input logic [2:0] ch, input int budget, output bit ok,
                             output int t_rise, output int t_fall);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trig[ch]) begin ok = 1'b1; break; end
        end
        t_rise = cyc;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < budget; i++) begin
                @(negedge clk);
                if (!trig[ch]) begin ok = 1'b1; break; end
            end
        end
        t_fall = cyc;
    endtask

    task automatic wait_upd(input int budget, output bit ok, output int t_upd);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (upd) begin ok = 1'b1; break; end
        end
        t_upd = cyc;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ch_mask = '0; echo = '0;
        enable_s = 1'b0; ch_mask_s = '0; echo_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (trig !== 6'b0) begin miscompares++; $display("FAIL reset_trig got=%b want=0", trig); end
        vectors++;
        if (upd !== 1'b0 || upd_to !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got upd=%b to=%b busy=%b want 0 0 0", upd, upd_to, busy);
        end
        vectors++;
        if (upd_ch !== 4'd0 || upd_val !== 16'd0) begin
            miscompares++; $display("FAIL reset_result got ch=%0d val=%h want 0 0", upd_ch, upd_val);
        end
        vectors++;
        if (dist_flat !== {NCH*W{1'b1}} || dist_flat_s !== {NCH*WS{1'b1}}) begin
            miscompares++; $display("FAIL reset_dist got=%h want all ones", dist_flat);
        end
        enable = 1'b1;
        repeat (50) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || trig !== 6'b0) begin
            miscompares++; $display("FAIL mask_zero_idle got busy=%b trig=%b want 0 0", busy, trig);
        end
        enable = 1'b0;
    endtask

    task automatic test_single_echo();
        bit ok;
        int tr, tf, tu, te;
        ch_mask = 6'b000001; enable = 1'b1;
        wait_trig(3'd0, 200, ok, tr, tf);
        vectors++;
        if (!ok || (tf - tr) != TRIG_CYC) begin
            miscompares++; $display("FAIL single_trig_width got=%0d want=%0d", tf - tr, TRIG_CYC);
        end
        repeat (100 * CLK_MHZ) @(negedge clk);
        echo[0] = 1'b1;
        repeat (580 * CLK_MHZ) @(negedge clk);
        echo[0] = 1'b0;
        te = cyc;
        wait_upd(50, ok, tu);
        enable = 1'b0;
        vectors++;
        if (!ok || upd_ch !== 4'd0 || upd_to !== 1'b0) begin
            miscompares++;
            $display("FAIL single_upd got ok=%0d ch=%0d to=%b want 1 0 0", ok, upd_ch, upd_to);
        end
        vectors++;
        if (upd_val < 16'd579 || upd_val > 16'd581) begin
            miscompares++; $display("FAIL single_val got=%0d want 579..581", upd_val);
        end
        vectors++;
        if ((tu - te) < 2 || (tu - te) > 3) begin
            miscompares++; $display("FAIL single_latency got=%0d want 2..3", tu - te);
        end
        vectors++;
        if (dist_flat[15:0] < 16'd579 || dist_flat[15:0] > 16'd581 ||
            dist_flat[31:16] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL single_dist got ch0=%0d ch1=%h want 579..581 FFFF",
                     dist_flat[15:0], dist_flat[31:16]);
        end
        wait_idle(GAP_CYC + 20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_park got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch [4] = '{3'd1, 3'd3, 3'd5, 3'd1};
        bit ok;
        int tr, tf, tu;
        tu = 0;
        ch_mask = 6'b101010; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_trig(exp_ch[k], GAP_CYC + 500, ok, tr, tf);
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL rr_trig[%0d] got trig=%b want ch%0d", k, trig, exp_ch[k]);
            end
            if (k > 0) begin
                vectors++;
                if ((tr - (tu + 1)) < GAP_CYC || (tr - (tu + 1)) > GAP_CYC + 2) begin
                    miscompares++;
                    $display("FAIL rr_gap[%0d] got=%0d want=%0d..%0d", k, tr - (tu + 1), GAP_CYC,
                             GAP_CYC + 2);
                end
            end
            repeat (20 * CLK_MHZ) @(negedge clk);
            echo[exp_ch[k]] = 1'b1;
            repeat (200 * CLK_MHZ) @(negedge clk);
            echo[exp_ch[k]] = 1'b0;
            wait_upd(50, ok, tu);
            if (k == 3) enable = 1'b0;
            vectors++;
            if (!ok || upd_ch !== {1'b0, exp_ch[k]} || upd_to !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_ch[%0d] got=%0d want=%0d", k, upd_ch, exp_ch[k]);
            end
            vectors++;
            if (upd_val < 16'd199 || upd_val > 16'd201) begin
                miscompares++; $display("FAIL rr_val[%0d] got=%0d want 199..201", k, upd_val);
            end
        end
        vectors++;
        if (overlap_err != 0) begin
            miscompares++; $display("FAIL trig_overlap got=%0d want=0", overlap_err);
        end
        wait_idle(GAP_CYC + 20, ok);
    endtask

    task automatic test_no_echo();
        bit ok;
        int tr, tf, tu;
        ch_mask = 6'b000100; enable = 1'b1;
        wait_trig(3'd2, GAP_CYC + 500, ok, tr, tf);
        wait_upd(TO_CYC + 100, ok, tu);
        enable = 1'b0;
        vectors++;
        if (!ok || (tu - tf) < TO_CYC - 2 || (tu - tf) > TO_CYC + 2) begin
            miscompares++; $display("FAIL noecho_time got=%0d want=%0d", tu - tf, TO_CYC);
        end
        vectors++;
        if (upd_ch !== 4'd2 || upd_val !== 16'hFFFF || upd_to !== 1'b1) begin
            miscompares++;
            $display("FAIL noecho_result got ch=%0d val=%h to=%b want 2 FFFF 1",
                     upd_ch, upd_val, upd_to);
        end
        vectors++;
        if (dist_flat[47:32] !== 16'hFFFF) begin
            miscompares++; $display("FAIL noecho_dist got=%h want FFFF", dist_flat[47:32]);
        end
        wait_idle(GAP_CYC + 20, ok);
    endtask

    task automatic test_stuck_high();
        bit ok;
        int tr, tf, tu;
        echo[0] = 1'b1;
        ch_mask = 6'b000001;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_trig(3'd0, 200, ok, tr, tf);
        wait_upd(TO_CYC + 100, ok, tu);
        enable = 1'b0;
        vectors++;
        if (!ok || upd_ch !== 4'd0 || upd_val !== 16'hFFFF || upd_to !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_result got ok=%0d ch=%0d val=%h to=%b want 1 0 FFFF 1",
                     ok, upd_ch, upd_val, upd_to);
        end
        vectors++;
        if (dist_flat[15:0] !== 16'hFFFF) begin
            miscompares++; $display("FAIL stuck_dist got=%h want FFFF", dist_flat[15:0]);
        end
        echo[0] = 1'b0;
        wait_idle(GAP_CYC + 20, ok);
    endtask

    task automatic test_enable_drop();
        bit ok, quiet;
        int tr, tf, tu;
        ch_mask = 6'b000001; enable = 1'b1;
        wait_trig(3'd0, 200, ok, tr, tf);
        repeat (10 * CLK_MHZ) @(negedge clk);
        echo[0] = 1'b1;
        repeat (50 * CLK_MHZ) @(negedge clk);
        enable = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL endrop_busy got=%b want 1", busy); end
        repeat (50 * CLK_MHZ) @(negedge clk);
        echo[0] = 1'b0;
        wait_upd(50, ok, tu);
        vectors++;
        if (!ok || upd_to !== 1'b0 || upd_val < 16'd99 || upd_val > 16'd101) begin
            miscompares++;
            $display("FAIL endrop_result got ok=%0d val=%0d to=%b want 1 99..101 0",
                     ok, upd_val, upd_to);
        end
        repeat (GAP_CYC - 10) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL endrop_gap got=%b want 1", busy); end
        wait_idle(30, ok);
        quiet = ok;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || trig !== 6'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++; $display("FAIL endrop_park got busy=%b trig=%b want 0 0", busy, trig);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int cnt0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ch_mask = 6'b111111; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (trig !== 6'b0) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok || trig !== 6'b000001) begin
            miscompares++; $display("FAIL first_channel got trig=%b want 000001", trig);
        end
        repeat (20) @(negedge clk);
        cnt0 = upd_cnt;
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (trig !== 6'b0) begin miscompares++; $display("FAIL rst_trig got=%b want 0", trig); end
        @(negedge clk);
        rst = 1'b0;
        repeat (TRIG_CYC + 50) @(negedge clk);
        vectors++;
        if (upd_cnt != cnt0 || busy !== 1'b0 || dist_flat !== {NCH*W{1'b1}}) begin
            miscompares++;
            $display("FAIL rst_after got upds=%0d busy=%b dist=%h want %0d 0 all ones",
                     upd_cnt, busy, dist_flat, cnt0);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        ch_mask_s = 6'b000001; enable_s = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (trig_s[0]) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 200 && trig_s[0]; i++) @(negedge clk);
        repeat (10 * CLK_MHZ) @(negedge clk);
        echo_s[0] = 1'b1;
        repeat (400 * CLK_MHZ) @(negedge clk);
        echo_s[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (upd_s) begin ok = 1'b1; break; end
        end
        enable_s = 1'b0;
        vectors++;
        if (!ok || upd_val_s !== 8'd254 || upd_to_s !== 1'b0 || upd_ch_s !== 4'd0) begin
            miscompares++;
            $display("FAIL sat_result got ok=%0d val=%0d to=%b ch=%0d want 1 254 0 0",
                     ok, upd_val_s, upd_to_s, upd_ch_s);
        end
        vectors++;
        if (dist_flat_s[7:0] !== 8'd254) begin
            miscompares++; $display("FAIL sat_dist got=%0d want 254", dist_flat_s[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_round_robin();
        test_no_echo();
        test_stuck_high();
        test_enable_drop();
        test_rst_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got cycle=%0d want finish before limit", cyc);
        $fatal(1);
    end

endmodule
